// File: rtl/data_pattern_generator.sv
// 128-bit test pattern source (PRBS7/15/23/31, lane counter, alternating) with a
// 32-bit CSR slave, valid/ready output handshake and one-shot bit-0 error injection.
module data_pattern_generator #(
  parameter int DATA_W = 128,  // multiple of 32
  parameter int CNT_W  = 32    // at most 32
) (
  input  logic              csr_clk_clk,
  input  logic              reset_reset_n,
  input  logic [2:0]        csr_slave_address,
  input  logic              csr_slave_write,
  input  logic              csr_slave_read,
  input  logic [3:0]        csr_slave_byteenable,
  input  logic [31:0]       csr_slave_writedata,
  output logic [31:0]       csr_slave_readdata,
  output logic [DATA_W-1:0] aso_data,
  output logic              aso_valid,
  input  logic              aso_ready
);
  localparam int LANES = DATA_W / 32;

  typedef enum logic [2:0] {
    PAT_PRBS7   = 3'd0,
    PAT_PRBS15  = 3'd1,
    PAT_PRBS23  = 3'd2,
    PAT_PRBS31  = 3'd3,
    PAT_COUNTER = 3'd4,
    PAT_ALT     = 3'd5
  } pat_e;

  typedef struct packed {
    logic [31:0]       state;
    logic [DATA_W-1:0] word;
  } prbs_t;

  // One word of a Fibonacci LFSR: DATA_W serial steps, step k lands in bit k.
  function automatic prbs_t prbs_run(input logic [31:0] seed, input logic [4:0] msb,
                                     input logic [4:0] tap);
    prbs_t r;
    logic  b;
    r.state = seed;
    r.word  = '0;
    for (int k = 0; k < DATA_W; k++) begin
      b         = r.state[msb] ^ r.state[tap];
      r.state   = {r.state[30:0], b};
      r.word[k] = b;
    end
    return r;
  endfunction

  logic             enable, inject_pending;
  logic [2:0]       pattern_sel;
  logic [CNT_W-1:0] word_count;
  logic [31:0]      lfsr, lane_cnt;

  logic        ctrl_wr, patsel_wr, enable_nxt, enable_rise, enable_fall;
  logic        accept, load, inject_set;
  pat_e        eff_pat;
  logic [31:0] seed, cnt_base, next_lfsr, rd_mux;
  logic [DATA_W-1:0] ctr_word, next_word;
  prbs_t       p7, p15, p23, p31;
  logic        unused;

  assign unused = ^{csr_slave_byteenable[3:1], csr_slave_writedata[31:3]};

  always_comb begin
    ctrl_wr     = csr_slave_write && csr_slave_address == 3'd0 && csr_slave_byteenable[0];
    patsel_wr   = csr_slave_write && csr_slave_address == 3'd1 && csr_slave_byteenable[0]
                  && !enable;
    enable_nxt  = ctrl_wr ? csr_slave_writedata[0] : enable;
    enable_rise = !enable && enable_nxt;
    enable_fall = enable && !enable_nxt;
    inject_set  = ctrl_wr && csr_slave_writedata[1];
    accept      = aso_valid && aso_ready;
    // A disable coinciding with an accept still counts the word but presents nothing new.
    load        = enable_rise || (accept && enable_nxt);
    eff_pat     = (pattern_sel > 3'd5) ? PAT_PRBS7 : pat_e'(pattern_sel);
    seed        = enable_rise ? '1 : lfsr;
    cnt_base    = enable_rise ? '0 : lane_cnt;
  end

  assign p7  = prbs_run(seed, 5'd6,  5'd5);
  assign p15 = prbs_run(seed, 5'd14, 5'd13);
  assign p23 = prbs_run(seed, 5'd22, 5'd17);
  assign p31 = prbs_run(seed, 5'd30, 5'd27);

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign ctr_word[32*i +: 32] = cnt_base * 32'(LANES) + 32'(i);
  end

  always_comb begin
    next_word = p7.word;
    next_lfsr = p7.state;
    case (eff_pat)
      PAT_PRBS15:  begin next_word = p15.word; next_lfsr = p15.state; end
      PAT_PRBS23:  begin next_word = p23.word; next_lfsr = p23.state; end
      PAT_PRBS31:  begin next_word = p31.word; next_lfsr = p31.state; end
      PAT_COUNTER: next_word = ctr_word;
      PAT_ALT:     next_word = {LANES{32'hAAAA_AAAA}};
      default:     ;
    endcase
  end

  always_comb begin
    rd_mux = '0;
    case (csr_slave_address)
      3'd0:    rd_mux = {30'd0, inject_pending, enable};
      3'd1:    rd_mux = {29'd0, pattern_sel};
      3'd2:    rd_mux = 32'(word_count);
      3'd3:    rd_mux = {25'd0, eff_pat, 2'b00, inject_pending, aso_valid};
      default: ;
    endcase
  end

  always_ff @(posedge csr_clk_clk) begin
    if (!reset_reset_n) begin
      enable             <= 1'b0;
      pattern_sel        <= '0;
      inject_pending     <= 1'b0;
      word_count         <= '0;
      lfsr               <= '1;
      lane_cnt           <= '0;
      aso_data           <= '0;
      aso_valid          <= 1'b0;
      csr_slave_readdata <= '0;
    end else begin
      enable <= enable_nxt;
      if (patsel_wr) pattern_sel <= csr_slave_writedata[2:0];
      if (load) begin
        aso_data <= next_word ^ DATA_W'(inject_pending);
        lfsr     <= next_lfsr;
        lane_cnt <= cnt_base + 32'd1;
      end
      if (enable_rise)      aso_valid <= 1'b1;
      else if (enable_fall) aso_valid <= 1'b0;
      // Pending flag is consumed by the load that uses its old value; a same-edge set re-arms it.
      inject_pending <= inject_set | (inject_pending & ~load);
      if (enable_rise)                  word_count <= '0;
      else if (accept && ~&word_count)  word_count <= word_count + CNT_W'(1);
      if (csr_slave_read) csr_slave_readdata <= rd_mux;
    end
  end
endmodule

// File: tb/tb_data_pattern_generator.sv
// Randomized bench for data_pattern_generator: a transaction-level model predicts
// aso_valid/aso_data/readdata every cycle, plus a few literal pattern checks.
module tb_data_pattern_generator;
  logic         clk = 1'b0, rst_n = 1'b0;
  logic [2:0]   addr = '0;
  logic         wr = 1'b0, rd = 1'b0, ready = 1'b0;
  logic [3:0]   be = '0;
  logic [31:0]  wdata = '0, readdata;
  logic [127:0] aso_data;
  logic         aso_valid;

  always #5 clk = ~clk;

  data_pattern_generator dut (
    .csr_clk_clk          (clk),
    .reset_reset_n        (rst_n),
    .csr_slave_address    (addr),
    .csr_slave_write      (wr),
    .csr_slave_read       (rd),
    .csr_slave_byteenable (be),
    .csr_slave_writedata  (wdata),
    .csr_slave_readdata   (readdata),
    .aso_data             (aso_data),
    .aso_valid            (aso_valid),
    .aso_ready            (ready)
  );

  int vectors = 0, miscompares = 0, rdy_mode = 0;
  bit chk_on = 0;

  // Model state
  logic         m_valid, m_en, m_pend;
  logic [2:0]   m_sel;
  logic [31:0]  m_cnt, m_lfsr, m_c, m_rd;
  logic [127:0] m_data;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      if (miscompares <= 20)
        $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [2:0] eff();
    return (m_sel > 3'd5) ? 3'd0 : m_sel;
  endfunction

  function automatic logic [31:0] csr_val(input logic [2:0] a);
    case (a)
      3'd0:    return {30'd0, m_pend, m_en};
      3'd1:    return {29'd0, m_sel};
      3'd2:    return m_cnt;
      3'd3:    return {25'd0, eff(), 2'b00, m_pend, m_valid};
      default: return 32'd0;
    endcase
  endfunction

  // Next word of the selected pattern, straight from the serial/lane definitions.
  task automatic gen_word(output logic [127:0] w);
    int n, t;
    logic [31:0] mask, b;
    w = '0;
    case (eff())
      3'd1:    begin n = 15; t = 14; end
      3'd2:    begin n = 23; t = 18; end
      3'd3:    begin n = 31; t = 28; end
      default: begin n = 7;  t = 6;  end
    endcase
    if (eff() < 3'd4) begin
      mask = (32'h1 << n) - 32'h1;
      for (int k = 0; k < 128; k++) begin
        b      = ((m_lfsr >> (n - 1)) ^ (m_lfsr >> (t - 1))) & 32'h1;
        m_lfsr = ((m_lfsr << 1) | b) & mask;
        w[k]   = b[0];
      end
    end else if (eff() == 3'd4) begin
      for (int i = 0; i < 4; i++) w[32*i +: 32] = m_c * 32'd4 + 32'(i);
      m_c = m_c + 32'd1;
    end else begin
      w = {4{32'hAAAA_AAAA}};
    end
  endtask

  task automatic model_edge();
    logic acc, old_en, new_en, old_pend, loaded, ctrl;
    if (!rst_n) begin
      m_valid = 0; m_en = 0; m_pend = 0; m_sel = 0; m_cnt = 0;
      m_lfsr = '1; m_c = 0; m_rd = 0; m_data = '0;
      return;
    end
    if (rd) m_rd = csr_val(addr);
    acc      = m_valid && ready;
    old_en   = m_en;
    old_pend = m_pend;
    ctrl     = wr && be[0] && addr == 3'd0;
    new_en   = ctrl ? wdata[0] : old_en;
    if (wr && be[0] && addr == 3'd1 && !old_en) m_sel = wdata[2:0];
    if (acc && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
    loaded = 0;
    if (!old_en && new_en) begin
      m_lfsr = '1; m_c = 0; m_cnt = 0;
      gen_word(m_data);
      loaded = 1; m_valid = 1;
    end else if (old_en && !new_en) begin
      m_valid = 0;
    end else if (acc) begin
      gen_word(m_data);
      loaded = 1;
    end
    if (loaded && old_pend) m_data[0] = ~m_data[0];
    m_pend = (old_pend && !loaded) || (ctrl && wdata[1]);
    m_en   = new_en;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    wr = 0; rd = 0;
    case (rdy_mode)
      0:       ready = 1'b1;
      1:       ready = ~ready;
      2:       ready = 1'($urandom_range(0, 1));
      default: ready = 1'b0;
    endcase
  endtask

  task automatic csr_wr(input logic [2:0] a, input logic [31:0] d, input logic [3:0] b);
    addr = a; wdata = d; be = b; wr = 1; tick();
  endtask

  task automatic csr_rd(input logic [2:0] a);
    addr = a; rd = 1; tick();
  endtask

  // Single compare process against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("aso_valid", 128'(aso_valid), 128'(m_valid));
      if (m_valid) chk("aso_data", aso_data, m_data);
      chk("readdata", 128'(readdata), 128'(m_rd));
    end
  end

  initial begin
    logic [127:0] exp_w;
    int r;
    logic [31:0] d;
    tick(); tick();
    rst_n = 1; chk_on = 1;
    chk("rst_valid", 128'(aso_valid), 128'd0);
    chk("rst_readdata", 128'(readdata), 128'd0);
    for (int a = 0; a < 8; a++) csr_rd(3'(a));
    csr_rd(3); chk("rst_status", 128'(readdata), 128'd0);

    // PRBS7 from seed, continuous ready
    rdy_mode = 0;
    csr_wr(1, 32'd0, 4'hF);
    csr_wr(0, 32'd1, 4'h1);
    chk("prbs7_bits0_6", 128'(aso_data[6:0]), 128'h40);
    chk("prbs7_bit127", 128'(aso_data[127]), 128'd0);
    chk("model_prbs7_bits", 128'(m_data[6:0]), 128'h40);
    repeat (10) tick();
    csr_rd(2); chk("wordcnt_10", 128'(readdata), 128'd10);

    // Counter with ready toggling
    csr_wr(0, 32'd0, 4'hF);
    csr_wr(1, 32'd4, 4'hF);
    rdy_mode = 1;
    csr_wr(0, 32'd1, 4'hF);
    exp_w = {32'd3, 32'd2, 32'd1, 32'd0};
    chk("counter_first", aso_data, exp_w);
    repeat (20) tick();
    csr_rd(2);

    // PRBS31 with injection during streaming
    csr_wr(0, 32'd0, 4'hF);
    csr_wr(1, 32'd3, 4'hF);
    rdy_mode = 2;
    csr_wr(0, 32'd1, 4'hF);
    repeat (15) tick();
    csr_wr(0, 32'd3, 4'h1);
    repeat (30) tick();

    // PATSEL locked while enabled, then PRBS23
    csr_wr(1, 32'd2, 4'hF);
    csr_rd(1); chk("patsel_locked", 128'(readdata), 128'd3);
    csr_wr(0, 32'd0, 4'hF);
    csr_wr(1, 32'd2, 4'hF);
    csr_wr(0, 32'd1, 4'hF);
    repeat (20) tick();
    csr_rd(1); chk("patsel_2", 128'(readdata), 128'd2);

    // ALT, then PATSEL=6 (behaves as PRBS7)
    csr_wr(0, 32'd0, 4'hF);
    csr_wr(1, 32'd5, 4'hF);
    csr_wr(0, 32'd1, 4'hF);
    exp_w = {4{32'hAAAA_AAAA}};
    chk("alt_word", aso_data, exp_w);
    repeat (5) tick();
    csr_wr(0, 32'd0, 4'hF);
    csr_wr(1, 32'd6, 4'hF);
    csr_wr(0, 32'd1, 4'hF);
    repeat (6) tick();

    // Disable during stall, re-enable restarts from seed
    rdy_mode = 3;
    tick(); tick();
    csr_wr(0, 32'd0, 4'hF);
    chk("stall_disable", 128'(aso_valid), 128'd0);
    csr_wr(0, 32'd1, 4'hF);
    chk("reenable_seed", 128'(aso_data[6:0]), 128'h40);
    csr_rd(2); chk("wordcnt_restart", 128'(readdata), 128'd0);
    csr_rd(3); chk("status_p6", 128'(readdata), 128'h1);

    // One-cycle reset mid-stream
    rdy_mode = 0;
    repeat (5) tick();
    rst_n = 0; tick(); rst_n = 1;
    chk("rst_mid_valid", 128'(aso_valid), 128'd0);
    csr_rd(3); chk("rst_mid_status", 128'(readdata), 128'd0);

    // Random traffic
    rdy_mode = 2;
    csr_wr(0, 32'd1, 4'hF);
    repeat (2000) begin
      r = $urandom_range(0, 999);
      if (r < 4) begin
        rst_n = 0; tick(); rst_n = 1;
      end else if (r < 30) begin
        d = $urandom;
        if ($urandom_range(0, 4) != 0) d[0] = 1'b1;
        csr_wr(0, d, 4'($urandom));
      end else if (r < 50) begin
        csr_wr(1, $urandom, 4'($urandom));
      end else if (r < 60) begin
        csr_wr(3'($urandom), $urandom, 4'($urandom));
      end else if (r < 200) begin
        csr_rd(3'($urandom));
      end else begin
        tick();
      end
    end

    chk_on = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
